fu_issue_ctrl: RTL and testbench
================================

# fu_issue_ctrl

Issue controller that drives the `functional_unit` datapath: it accepts tagged operations on a valid/ready port, queues them, and presents them to the FU's A/B/C/INST/SELECT inputs at up to one per cycle. It captures Z/COMPARE on the FU's fixed one-cycle latency and returns tagged results through a buffered valid/ready output. It owns every FU input, so the FU never sees an unqualified operand.

## Interface
Parameters:
- `DEPTH`, 4: input queue entries; power of 2, minimum 2.
- `TAG_W`, 4: width of the tag carried with each operation.

Ports:
- `CLOCK` in 1: sole clock; all state updates on rising edge.
- `RESET` in 1: synchronous, active-high.
- `IN_VALID` in 1 / `IN_READY` out 1: operation handshake.
- `IN_INST` in 6: FU opcode.
- `IN_A`, `IN_B`, `IN_C` in 32 each: operands.
- `IN_SELECT` in 1: mux select bit.
- `IN_TAG` in TAG_W: opaque tag.
- `IN_USE_CMP` in 1: take SELECT from the last compare result. Present only with `FU_ISSUE_CMP_SEL_EN`.
- `FU_A`, `FU_B`, `FU_C` out 32 each; `FU_INST` out 6; `FU_SELECT` out 1: registered drive to the FU.
- `FU_Z` in 32; `FU_COMPARE` in 1: FU results.
- `OUT_VALID` out 1 / `OUT_READY` in 1: result handshake.
- `OUT_Z` out 32; `OUT_COMPARE` out 1; `OUT_TAG` out TAG_W.
- `BUSY` out 1: any queue, pipeline or output entry occupied.

## Operation
- **Input queue:** circular FIFO of DEPTH entries.
  - `IN_READY` = queue not full, from registered state.
  - An entry is accepted on a rising edge with `IN_VALID & IN_READY`.
- **S1, issue register:**
  - The queue head pops into the FU_* registers plus tag/valid when the queue is non-empty, credit is available and no compare stall applies.
  - When no pop occurs, FU_* hold their values; the S1 valid bit clears.
- **S2:** the tag/valid/compare-op flag follow S1 one edge later, while the FU samples FU_*.
- **Capture:** at the next edge, S2-valid writes {FU_Z, FU_COMPARE, tag} into a 4-entry output FIFO.
- **Credit rule:** pop allowed iff S1valid + S2valid + out_count ≤ 3, using registered counts. Results are therefore never dropped.
- **Output:** the output FIFO head drives OUT_*. An entry pops on `OUT_VALID & OUT_READY`. OUT_* hold stable while `OUT_VALID & ~OUT_READY`.
- **Compare ops:** opcodes 001110, 001111 and 01xxxx.
- **Ordering:** results return strictly in acceptance order.
- **Simultaneous events:** push and pop in one cycle are legal on both FIFOs. A full input queue that pops that cycle still deasserts `IN_READY` (registered full).

## Timing
- Accepted at edge e, with empty pipeline and `OUT_READY`=1:
  - pop at e+1;
  - FU samples at e+2;
  - `OUT_VALID` high after e+3.
- Latency is 3 cycles; sustained throughput is 1 op/cycle.
- **Reset:** on an edge with `RESET`=1:
  - queue, S1, S2, output FIFO and cmp_flag are cleared;
  - FU_* = 0, `OUT_VALID`=0, `OUT_Z`=0, `OUT_COMPARE`=0, `OUT_TAG`=0, `BUSY`=0;
  - `IN_READY`=1 from the first cycle after reset.
- **Reset mid-operation:** all in-flight ops are discarded, including the one inside the FU. Its result is never captured.
- `BUSY` is registered and reflects occupancy after the edge.

## Configuration
- **`FU_ISSUE_CMP_SEL_EN` defined:**
  - cmp_flag register, updated at capture of every compare op with FU_COMPARE.
  - For a head entry with `IN_USE_CMP`=1, FU_SELECT is chosen by priority:
    - S1 holds a compare op: stall pop one cycle (`IN_READY` unaffected).
    - Else S2 holds a compare op: forward live `FU_COMPARE`.
    - Else: cmp_flag.
- **Undefined:**
  - `IN_USE_CMP` port and cmp_flag are absent.
  - FU_SELECT = `IN_SELECT` of the entry; no stalls beyond credit.

## Test plan
- **Single ADD:** ADD (000010), A=5, B=7, tag=3 → `OUT_VALID` exactly 3 cycles after accept; OUT_Z=12, OUT_COMPARE=0, OUT_TAG=3.
- **Streaming:** 32 back-to-back random ops, `OUT_READY`=1 → one result per cycle, in order, each matching the FU golden model; `IN_READY` never deasserts.
- **Backpressure:** `OUT_READY`=0 while issuing 10 ops → exactly 4 results buffered. The queue fills, `IN_READY`=0, OUT_* stable. Releasing `OUT_READY` yields all 10 in order, none lost.
- **Compare-forward stall (macro on):** LT (A=-1, B=2) immediately followed by SELECT with IN_USE_CMP=1 (A=0xAA, B=0xBB) → one-cycle issue bubble; results COMPARE=1, then Z=0xBB. With one unrelated op between them, there is no bubble and Z=0xBB (S2 forward).
- **Reset mid-stream:** RESET for one cycle with 3 ops in flight → no stale `OUT_VALID`; `BUSY`=0 and FU_*=0 after the edge. A following ADD 1+1 returns 2 with the correct tag.
- **Wrap-around:** 3×DEPTH ops with random `IN_VALID`/`OUT_READY` gaps → pointer wrap is correct and all tags return in order.

Source files
------------

// File: rtl/fu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fu_issue_ctrl
// Description : Queues tagged operations, issues them to a one-cycle-latency
//               functional_unit and returns tagged results through a 4-entry
//               output FIFO. Optional macro FU_ISSUE_CMP_SEL_EN adds
//               IN_USE_CMP (SELECT taken from the last compare result).
// Revision    : 1.0 - initial release
// ============================================================================
module fu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [5:0]       IN_INST,
    input  logic [31:0]      IN_A,
    input  logic [31:0]      IN_B,
    input  logic [31:0]      IN_C,
    input  logic             IN_SELECT,
    input  logic [TAG_W-1:0] IN_TAG,
`ifdef FU_ISSUE_CMP_SEL_EN
    input  logic             IN_USE_CMP,
`endif
    output logic [31:0]      FU_A,
    output logic [31:0]      FU_B,
    output logic [31:0]      FU_C,
    output logic [5:0]       FU_INST,
    output logic             FU_SELECT,
    input  logic [31:0]      FU_Z,
    input  logic             FU_COMPARE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      OUT_Z,
    output logic             OUT_COMPARE,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             BUSY
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    function automatic logic f_is_cmp(input logic [5:0] op);
        return (op == 6'b001110) || (op == 6'b001111) || (op[5:4] == 2'b01);
    endfunction

    // Input queue storage and pointers
    logic [5:0]       r_q_inst [DEPTH];
    logic [31:0]      r_q_a    [DEPTH];
    logic [31:0]      r_q_b    [DEPTH];
    logic [31:0]      r_q_c    [DEPTH];
    logic             r_q_sel  [DEPTH];
    logic [TAG_W-1:0] r_q_tag  [DEPTH];
    logic [c_AW-1:0]  r_q_wr;
    logic [c_AW-1:0]  r_q_rd;
    logic [c_CW-1:0]  r_q_cnt;
    logic [c_CW-1:0]  w_q_cnt_nxt;

    // Issue (S1) and FU-sampling (S2) stages
    logic [31:0]      r_fu_a;
    logic [31:0]      r_fu_b;
    logic [31:0]      r_fu_c;
    logic [5:0]       r_fu_inst;
    logic             r_fu_sel;
    logic             r_s1_v;
    logic             r_s1_cmp;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s2_v;
    logic             r_s2_cmp;
    logic [TAG_W-1:0] r_s2_tag;

    // Output FIFO
    logic [31:0]      r_o_z   [4];
    logic             r_o_c   [4];
    logic [TAG_W-1:0] r_o_tag [4];
    logic [1:0]       r_o_wr;
    logic [1:0]       r_o_rd;
    logic [2:0]       r_o_cnt;
    logic [2:0]       w_o_cnt_nxt;
    logic             r_busy;

    logic             w_push;
    logic             w_pop;
    logic             w_credit;
    logic             w_stall;
    logic             w_sel;
    logic             w_o_push;
    logic             w_o_pop;
    logic [2:0]       w_occ;

    assign IN_READY = (r_q_cnt != c_CW'(DEPTH));
    assign w_push   = IN_VALID & IN_READY;

    // Every op in S1/S2 already owns an output slot, so capture can never overflow.
    assign w_occ    = 3'(r_s1_v) + 3'(r_s2_v) + r_o_cnt;
    assign w_credit = (w_occ <= 3'd3);

`ifdef FU_ISSUE_CMP_SEL_EN
    logic r_q_ucmp [DEPTH];
    logic r_cmp_flag;

    // Compare in S1 has no result yet; in S2 its result is live on FU_COMPARE.
    always_comb begin
        w_stall = 1'b0;
        w_sel   = r_q_sel[r_q_rd];
        if (r_q_ucmp[r_q_rd]) begin
            if (r_s1_v && r_s1_cmp) begin
                w_stall = 1'b1;
            end else if (r_s2_v && r_s2_cmp) begin
                w_sel = FU_COMPARE;
            end else begin
                w_sel = r_cmp_flag;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (w_push) begin
            r_q_ucmp[r_q_wr] <= IN_USE_CMP;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_cmp_flag <= 1'b0;
        end else if (r_s2_v && r_s2_cmp) begin
            r_cmp_flag <= FU_COMPARE;
        end
    end
`else
    assign w_stall = 1'b0;
    assign w_sel   = r_q_sel[r_q_rd];
`endif

    assign w_pop       = (r_q_cnt != '0) & w_credit & ~w_stall;
    assign w_q_cnt_nxt = r_q_cnt + c_CW'(w_push) - c_CW'(w_pop);

    always_ff @(posedge CLOCK) begin
        if (w_push) begin
            r_q_inst[r_q_wr] <= IN_INST;
            r_q_a[r_q_wr]    <= IN_A;
            r_q_b[r_q_wr]    <= IN_B;
            r_q_c[r_q_wr]    <= IN_C;
            r_q_sel[r_q_wr]  <= IN_SELECT;
            r_q_tag[r_q_wr]  <= IN_TAG;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_q_wr  <= '0;
            r_q_rd  <= '0;
            r_q_cnt <= '0;
        end else begin
            if (w_push) begin
                r_q_wr <= r_q_wr + 1'b1;
            end
            if (w_pop) begin
                r_q_rd <= r_q_rd + 1'b1;
            end
            r_q_cnt <= w_q_cnt_nxt;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_fu_a    <= '0;
            r_fu_b    <= '0;
            r_fu_c    <= '0;
            r_fu_inst <= '0;
            r_fu_sel  <= 1'b0;
            r_s1_v    <= 1'b0;
            r_s1_cmp  <= 1'b0;
            r_s1_tag  <= '0;
            r_s2_v    <= 1'b0;
            r_s2_cmp  <= 1'b0;
            r_s2_tag  <= '0;
        end else begin
            r_s1_v <= w_pop;
            if (w_pop) begin
                r_fu_a    <= r_q_a[r_q_rd];
                r_fu_b    <= r_q_b[r_q_rd];
                r_fu_c    <= r_q_c[r_q_rd];
                r_fu_inst <= r_q_inst[r_q_rd];
                r_fu_sel  <= w_sel;
                r_s1_cmp  <= f_is_cmp(r_q_inst[r_q_rd]);
                r_s1_tag  <= r_q_tag[r_q_rd];
            end
            r_s2_v   <= r_s1_v;
            r_s2_cmp <= r_s1_cmp;
            r_s2_tag <= r_s1_tag;
        end
    end

    assign FU_A      = r_fu_a;
    assign FU_B      = r_fu_b;
    assign FU_C      = r_fu_c;
    assign FU_INST   = r_fu_inst;
    assign FU_SELECT = r_fu_sel;

    assign w_o_push    = r_s2_v;
    assign w_o_pop     = OUT_VALID & OUT_READY;
    assign w_o_cnt_nxt = r_o_cnt + 3'(w_o_push) - 3'(w_o_pop);

    always_ff @(posedge CLOCK) begin
        if (w_o_push) begin
            r_o_z[r_o_wr]   <= FU_Z;
            r_o_c[r_o_wr]   <= FU_COMPARE;
            r_o_tag[r_o_wr] <= r_s2_tag;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_o_wr  <= '0;
            r_o_rd  <= '0;
            r_o_cnt <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (w_o_push) begin
                r_o_wr <= r_o_wr + 1'b1;
            end
            if (w_o_pop) begin
                r_o_rd <= r_o_rd + 1'b1;
            end
            r_o_cnt <= w_o_cnt_nxt;
            r_busy  <= (w_q_cnt_nxt != '0) | w_pop | r_s1_v | (w_o_cnt_nxt != '0);
        end
    end

    assign OUT_VALID   = (r_o_cnt != '0);
    assign OUT_Z       = OUT_VALID ? r_o_z[r_o_rd]   : '0;
    assign OUT_COMPARE = OUT_VALID ? r_o_c[r_o_rd]   : 1'b0;
    assign OUT_TAG     = OUT_VALID ? r_o_tag[r_o_rd] : '0;
    assign BUSY        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fu_issue_ctrl
// Description : Self-checking bench for fu_issue_ctrl with a behavioural
//               one-cycle functional_unit and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    localparam logic [5:0] OP_ADD = 6'b000010;
    localparam logic [5:0] OP_SEL = 6'b000101;
    localparam logic [5:0] OP_LT  = 6'b001110;
    localparam logic [5:0] OP_EQ  = 6'b001111;

    logic              CLOCK = 1'b0;
    logic              RESET = 1'b1;
    logic              IN_VALID = 1'b0;
    logic              IN_READY;
    logic [5:0]        IN_INST = '0;
    logic [31:0]       IN_A = '0;
    logic [31:0]       IN_B = '0;
    logic [31:0]       IN_C = '0;
    logic              IN_SELECT = 1'b0;
    logic [TAG_W-1:0]  IN_TAG = '0;
`ifdef FU_ISSUE_CMP_SEL_EN
    logic              IN_USE_CMP = 1'b0;
`endif
    logic [31:0]       FU_A, FU_B, FU_C;
    logic [5:0]        FU_INST;
    logic              FU_SELECT;
    logic [31:0]       FU_Z = '0;
    logic              FU_COMPARE = 1'b0;
    logic              OUT_VALID;
    logic              OUT_READY = 1'b1;
    logic [31:0]       OUT_Z;
    logic              OUT_COMPARE;
    logic [TAG_W-1:0]  OUT_TAG;
    logic              BUSY;

    typedef struct {
        logic [31:0]      z;
        logic             c;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   out_cyc[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_got = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   tot_waits = 0;
    logic m_flag = 1'b0;
    bit   wr_done = 1'b0;

    fu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INST(IN_INST),
        .IN_A(IN_A), .IN_B(IN_B), .IN_C(IN_C), .IN_SELECT(IN_SELECT), .IN_TAG(IN_TAG),
`ifdef FU_ISSUE_CMP_SEL_EN
        .IN_USE_CMP(IN_USE_CMP),
`endif
        .FU_A(FU_A), .FU_B(FU_B), .FU_C(FU_C), .FU_INST(FU_INST), .FU_SELECT(FU_SELECT),
        .FU_Z(FU_Z), .FU_COMPARE(FU_COMPARE),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_Z(OUT_Z),
        .OUT_COMPARE(OUT_COMPARE), .OUT_TAG(OUT_TAG), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    // Behavioural functional unit: {compare, z}
    function automatic logic [32:0] fu_f(input logic [5:0] op, input logic [31:0] a, b, c,
                                         input logic s);
        logic [32:0] r;
        r = '0;
        casez (op)
            6'b000010: r[31:0] = a + b;
            6'b000011: r[31:0] = a - b;
            6'b000100: r[31:0] = a & b;
            6'b000101: r[31:0] = s ? b : a;
            6'b000110: r[31:0] = a ^ b ^ c;
            6'b001110: r[32]   = ($signed(a) < $signed(b));
            6'b001111: r[32]   = (a == b);
            6'b01????: begin r[32] = (a < b); r[31:0] = a - b; end
            default:   r[31:0] = a | b;
        endcase
        return r;
    endfunction

    function automatic logic is_cmp(input logic [5:0] op);
        return (op == 6'b001110) || (op == 6'b001111) || (op[5:4] == 2'b01);
    endfunction

    function automatic logic [5:0] pick_op(input int k);
        case (k)
            0: return 6'b000010;
            1: return 6'b000011;
            2: return 6'b000100;
            3: return 6'b000101;
            4: return 6'b000110;
            5: return 6'b001110;
            6: return 6'b001111;
            default: return 6'b010110;
        endcase
    endfunction

    always @(posedge CLOCK) {FU_COMPARE, FU_Z} <= fu_f(FU_INST, FU_A, FU_B, FU_C, FU_SELECT);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every handshake pops the oldest expected result.
    always @(negedge CLOCK) begin
        if (!RESET && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_z", 64'(OUT_Z), 64'(e.z));
                chk("out_cmp", 64'(OUT_COMPARE), 64'(e.c));
                chk("out_tag", 64'(OUT_TAG), 64'(e.tag));
                n_got++;
                out_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [5:0] op, input logic [31:0] a, b, c, input logic s, u,
                        input logic [TAG_W-1:0] tg, input int tmo, output bit ok);
        logic [32:0] r;
        int w;
        ok = 1'b0;
        w = 0;
        @(negedge CLOCK);
        IN_VALID = 1'b1; IN_INST = op; IN_A = a; IN_B = b; IN_C = c;
        IN_SELECT = s; IN_TAG = tg;
`ifdef FU_ISSUE_CMP_SEL_EN
        IN_USE_CMP = u;
`endif
        while (!ok && w < tmo) begin
            if (IN_READY) begin
                r = fu_f(op, a, b, c, u ? m_flag : s);
                if (is_cmp(op)) m_flag = r[32];
                sb.push_back('{z: r[31:0], c: r[32], tag: tg});
                @(posedge CLOCK); #1;
                IN_VALID = 1'b0;
                acc_cyc = cyc;
                ok = 1'b1;
            end else begin
                w++;
                @(negedge CLOCK);
            end
        end
        if (!ok) IN_VALID = 1'b0;
        tot_waits += w;
    endtask

    task automatic drain(input string tag, input int bound);
        for (int k = 0; k < bound && sb.size() != 0; k++) begin
            @(posedge CLOCK); #1;
        end
        chk(tag, 64'(sb.size()), 64'd0);
        chk("idle_busy", 64'(BUSY), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lat, base, acc, g0;

        // Reset state
        repeat (3) @(posedge CLOCK);
        #1 RESET = 1'b0;
        chk("rst_in_ready", 64'(IN_READY), 64'd1);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_fu_a", 64'(FU_A), 64'd0);
        chk("rst_fu_inst", 64'(FU_INST), 64'd0);
        chk("rst_out_z", 64'(OUT_Z), 64'd0);
        chk("rst_out_tag", 64'(OUT_TAG), 64'd0);

        // Single ADD and its latency
        send(OP_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 4'd3, 10, ok);
        chk("add_accept", 64'(ok), 64'd1);
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLOCK);
            if (OUT_VALID) begin
                lat = cyc - acc_cyc;
                break;
            end
        end
        chk("add_latency", 64'(lat), 64'd3);
        drain("add_drain", 20);

        // Streaming: 32 back-to-back ops
        base = out_cyc.size();
        tot_waits = 0;
        for (int i = 0; i < 32; i++) begin
            send(pick_op($urandom_range(0, 7)), 32'($urandom_range(0, 7)),
                 32'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'b0, 4'(i), 10, ok);
        end
        chk("stream_no_stall", 64'(tot_waits), 64'd0);
        drain("stream_drain", 50);
        chk("stream_count", 64'(out_cyc.size() - base), 64'd32);
        if (out_cyc.size() >= base + 32)
            chk("stream_rate", 64'(out_cyc[base+31] - out_cyc[base]), 64'd31);

        // Backpressure
        g0 = n_got;
        OUT_READY = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            send(OP_ADD, 32'(i), 32'd100, 32'd0, 1'b0, 1'b0, 4'(i), 12, ok);
            if (!ok) break;
            acc++;
        end
        chk("bp_accepted", 64'(acc), 64'd8);
        chk("bp_in_ready", 64'(IN_READY), 64'd0);
        chk("bp_out_valid", 64'(OUT_VALID), 64'd1);
        chk("bp_busy", 64'(BUSY), 64'd1);
        repeat (3) begin
            @(negedge CLOCK);
            chk("bp_hold_z", 64'(OUT_Z), 64'(sb[0].z));
            chk("bp_hold_tag", 64'(OUT_TAG), 64'(sb[0].tag));
        end
        @(posedge CLOCK); #1 OUT_READY = 1'b1;
        for (int i = acc; i < 10; i++) begin
            send(OP_ADD, 32'(i), 32'd100, 32'd0, 1'b0, 1'b0, 4'(i), 20, ok);
            chk("bp_late_accept", 64'(ok), 64'd1);
        end
        drain("bp_drain", 40);
        chk("bp_count", 64'(n_got - g0), 64'd10);

`ifdef FU_ISSUE_CMP_SEL_EN
        // Compare-select: S1 stall, then S2 forward
        base = out_cyc.size();
        send(OP_LT, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b0, 4'd1, 10, ok);
        send(OP_SEL, 32'hAA, 32'hBB, 32'd0, 1'b0, 1'b1, 4'd2, 10, ok);
        drain("cmp_stall_drain", 20);
        if (out_cyc.size() >= base + 2)
            chk("cmp_stall_gap", 64'(out_cyc[base+1] - out_cyc[base]), 64'd2);
        send(OP_EQ, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 4'd6, 10, ok);
        drain("cmp_eq_drain", 20);
        base = out_cyc.size();
        send(OP_LT, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b0, 4'd3, 10, ok);
        send(OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 4'd4, 10, ok);
        send(OP_SEL, 32'hAA, 32'hBB, 32'd0, 1'b0, 1'b1, 4'd5, 10, ok);
        drain("cmp_fwd_drain", 20);
        if (out_cyc.size() >= base + 3)
            chk("cmp_fwd_gap", 64'(out_cyc[base+2] - out_cyc[base+1]), 64'd1);
`endif

        // Reset with ops in flight
        for (int i = 0; i < 3; i++) begin
            send(OP_ADD, 32'(i), 32'd9, 32'd0, 1'b0, 1'b0, 4'(i + 8), 10, ok);
        end
        RESET = 1'b1;
        sb.delete();
        m_flag = 1'b0;
        @(posedge CLOCK); #1 RESET = 1'b0;
        chk("mid_rst_busy", 64'(BUSY), 64'd0);
        chk("mid_rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("mid_rst_fu", 64'({FU_A, FU_INST, FU_SELECT} == '0), 64'd1);
        chk("mid_rst_fu_bc", 64'({FU_B, FU_C} == '0), 64'd1);
        chk("mid_rst_in_ready", 64'(IN_READY), 64'd1);
        repeat (6) @(posedge CLOCK);
        #1;
        g0 = n_got;
        send(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 4'd9, 10, ok);
        drain("post_rst_drain", 20);
        chk("post_rst_count", 64'(n_got - g0), 64'd1);

        // Wrap-around with random gaps on both sides
        g0 = n_got;
        wr_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * DEPTH; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge CLOCK);
                    send(pick_op($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                         1'($urandom), 1'b0, 4'(i), 60, ok);
                    chk("wrap_accept", 64'(ok), 64'd1);
                end
                wr_done = 1'b1;
            end
            begin
                for (int k = 0; k < 600 && !wr_done; k++) begin
                    @(posedge CLOCK); #1 OUT_READY = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge CLOCK); #1 OUT_READY = 1'b1;
        drain("wrap_drain", 40);
        chk("wrap_count", 64'(n_got - g0), 64'(3 * DEPTH));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
